// File: rtl/gouram_trace_drain.sv
// Trace drain: buffers 160-bit gouram trace records in a small FIFO and
// serialises each one LSB-first into 32-bit beats on a valid/ready stream.
module gouram_trace_drain #(
  parameter int RECORD_WIDTH = 160,
  parameter int BEAT_WIDTH   = 32,
  parameter int BEATS        = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [RECORD_WIDTH-1:0] trace_data_i,
  input  logic                    trace_valid_i,
  output logic [BEAT_WIDTH-1:0]   beat_data_o,
  output logic                    beat_valid_o,
  input  logic                    beat_ready_i,
  output logic                    beat_last_o,
  output logic                    hold_o,
  output logic                    busy_o,
  output logic [31:0]             records_sent_o,
  output logic [15:0]             records_dropped_o,
  output logic                    fsm_state
);

  // Beat stream: a beat transfers on a cycle where beat_valid_o & beat_ready_i;
  // once raised, beat_valid_o, beat_data_o and beat_last_o hold until that transfer.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LVL = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state, state_d;
  logic [RECORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count, count_d;
  logic [IDX_W-1:0]        beat_idx, idx_d;
  logic [RECORD_WIDTH-1:0] rec_q;
  logic                    push, drop, pop, fire, last;

  assign fsm_state    = state;
  assign last         = (beat_idx == LAST_IDX);
  assign fire         = (state == SEND) && beat_ready_i;
  assign beat_valid_o = (state == SEND);
  assign beat_last_o  = (state == SEND) && last;
  assign beat_data_o  = rec_q[beat_idx * BEAT_WIDTH +: BEAT_WIDTH];

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign push = trace_valid_i && enable_i && (count < FULL);
  assign drop = trace_valid_i && enable_i && (count == FULL);

  always_comb begin
    state_d = state;
    idx_d   = beat_idx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            idx_d = '0;
            if (count != '0) pop = 1'b1;
            else state_d = IDLE;
          end else begin
            idx_d = beat_idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      beat_idx          <= '0;
      rec_q             <= '0;
      hold_o            <= 1'b0;
      busy_o            <= 1'b0;
      records_sent_o    <= '0;
      records_dropped_o <= '0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      beat_idx <= idx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rec_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      hold_o <= (count_d >= HOLD_LVL);
      busy_o <= (count_d != '0) || (state_d != IDLE);
      if (fire && last) records_sent_o <= records_sent_o + 32'd1;
      if (drop && records_dropped_o != 16'hFFFF)
        records_dropped_o <= records_dropped_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Bench for gouram_trace_drain: a record-level reference model predicts accepted
// records, drops and flags; a monitor checks every transferred beat in order.
module tb_gouram_trace_drain;

  localparam int RW = 160;
  localparam int BW = 32;
  localparam int NB = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [RW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          ready = 1'b0;
  logic [BW-1:0] beat_data;
  logic          beat_valid, beat_last, hold, busy, fsm_state;
  logic [31:0]   sent;
  logic [15:0]   dropped;

  always #5 clk = ~clk;

  gouram_trace_drain dut (
    .clk(clk), .rst(rst), .enable_i(enable), .trace_data_i(tdata),
    .trace_valid_i(tvalid), .beat_data_o(beat_data), .beat_valid_o(beat_valid),
    .beat_ready_i(ready), .beat_last_o(beat_last), .hold_o(hold), .busy_o(busy),
    .records_sent_o(sent), .records_dropped_o(dropped), .fsm_state(fsm_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [BW:0] exp_q[$];

  // Reference model: records waiting, record on the wire, beats already sent.
  int m_count = 0;
  bit m_infl = 0;
  int m_beat = 0;
  int m_sent = 0;
  int m_drop = 0;

  bit          prev_stall = 0;
  logic [BW:0] prev_beat = '0;

  task automatic cmp(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model step, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      cmp("beat_valid", RW'(beat_valid), RW'(m_infl));
      cmp("hold", RW'(hold), RW'(m_count >= DEPTH - 1));
      cmp("busy", RW'(busy), RW'(m_count > 0 || m_infl));
      cmp("records_sent", RW'(sent), RW'(m_sent));
      cmp("records_dropped", RW'(dropped), RW'(m_drop));
      if (prev_stall && beat_valid)
        cmp("stall_stable", RW'({beat_last, beat_data}), RW'(prev_beat));
      if (beat_valid && ready) begin
        if (exp_q.size() == 0) cmp("unexpected_beat", RW'({beat_last, beat_data}), '1);
        else cmp("beat", RW'({beat_last, beat_data}), RW'(exp_q.pop_front()));
      end
    end
    prev_stall = beat_valid && !ready && !rst;
    prev_beat  = {beat_last, beat_data};

    if (rst) begin
      m_count = 0; m_infl = 0; m_beat = 0; m_sent = 0; m_drop = 0;
      exp_q.delete();
    end else begin
      bit pop;
      bit acc;
      pop = (m_count > 0) && (!m_infl || (m_beat == NB - 1 && ready));
      acc = 0;
      if (!m_infl) begin
        if (pop) begin m_infl = 1; m_beat = 0; end
      end else if (ready) begin
        if (m_beat == NB - 1) begin
          m_sent++;
          m_infl = pop;
          m_beat = 0;
        end else m_beat++;
      end
      if (tvalid && enable) begin
        if (m_count < DEPTH) begin
          acc = 1;
          for (int b = 0; b < NB; b++)
            exp_q.push_back({b == NB - 1, tdata[b*BW +: BW]});
        end else if (m_drop < 16'hFFFF) m_drop++;
      end
      m_count = m_count + int'(acc) - int'(pop);
    end
  end

  task automatic drive(input bit v, input logic [RW-1:0] d, input bit en, input bit rdy);
    tvalid = v; tdata = d; enable = en; ready = rdy;
    @(posedge clk); #1;
  endtask

  function automatic logic [RW-1:0] rand_rec();
    logic [RW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*BW +: BW] = $urandom;
    return r;
  endfunction

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, '0, 1, rdy);
  endtask

  initial begin
    logic [RW-1:0] rec1;
    int pushed;
    int guard;
    rec1 = {32'h4, 32'h0, 32'h3, 32'h0, 32'h2};
    rec1 = {32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single record, LSB-first beats, two-cycle first-beat latency.
    drive(1, rec1, 1, 1);
    idle(10, 1);

    // Three back-to-back records with ready high: continuous beats.
    for (int i = 0; i < 3; i++) drive(1, rand_rec(), 1, 1);
    idle(20, 1);

    // Sink stalled: six pushes fill FIFO plus in-flight slot, one dropped.
    for (int i = 0; i < 6; i++) drive(1, rand_rec(), 1, 0);
    idle(8, 0);
    idle(40, 1);

    // 200 records with random arrival and random sink readiness.
    pushed = 0;
    guard = 0;
    while (pushed < 200 && guard < 20000) begin
      bit v;
      v = ($urandom_range(0, 9) < 2);
      drive(v, rand_rec(), 1, $urandom_range(0, 9) < 6);
      if (v) pushed++;
      guard++;
    end
    idle(60, 1);

    // Reset in the middle of a record.
    drive(1, rand_rec(), 1, 1);
    guard = 0;
    while (!(m_infl && m_beat == 2) && guard < 20) begin
      drive(0, '0, 1, 1);
      guard++;
    end
    cmp("reach_beat2", RW'(m_infl && m_beat == 2), RW'(1));
    rst = 1'b1;
    drive(0, '0, 1, 1);
    rst = 1'b0;
    #1;
    cmp("rst_data", RW'(beat_data), '0);
    cmp("rst_valid", RW'(beat_valid), '0);
    cmp("rst_last", RW'(beat_last), '0);
    cmp("rst_hold", RW'(hold), '0);
    cmp("rst_busy", RW'(busy), '0);
    cmp("rst_sent", RW'(sent), '0);
    cmp("rst_dropped", RW'(dropped), '0);
    @(posedge clk); #1;
    drive(1, rec1, 1, 1);
    idle(10, 1);

    // Disabled capture: pulses ignored, nothing dropped, stays idle.
    for (int i = 0; i < 10; i++) begin
      drive(1, rand_rec(), 0, 1);
      drive(0, '0, 0, 1);
    end
    idle(3, 1);
    cmp("disabled_busy", RW'(busy), '0);
    cmp("disabled_dropped", RW'(dropped), '0);
    cmp("exp_q_drained", RW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
